// File: rtl/tap_averager_pkg.sv
// Shared helpers for consumers of the flattened delay-line tap bus:
// width derivation and the per-tap slice function.
package tap_averager_pkg;

  // Upper bounds for the generic tap-slice helper; callers cast into and out of these.
  localparam int TAP_BUS_MAX_W  = 4096;
  localparam int TAP_WORD_MAX_W = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int sum_width(input int bits, input int taps);
    return bits + clog2(taps);
  endfunction

  // Word k of a tap bus whose words are `bits` wide; tap 0 sits in the LSBs.
  function automatic logic [TAP_WORD_MAX_W-1:0] tap(input logic [TAP_BUS_MAX_W-1:0] bus,
                                                    input int bits, input int k);
    logic [TAP_WORD_MAX_W-1:0] mask;
    mask = (bits >= TAP_WORD_MAX_W) ? '1 : ((64'd1 << bits) - 64'd1);
    return TAP_WORD_MAX_W'(bus >> (k * bits)) & mask;
  endfunction

endpackage

// File: rtl/tap_averager_adder.sv
// Combinational reduction of TAPS extended tap words into one SUM_W-bit sum.
module tap_adder
  import tap_averager_pkg::*;
#(
  parameter int TAPS   = 4,
  parameter int BITS   = 8,
  parameter int SIGNED = 0,
  parameter int SUM_W  = 10
) (
  input  logic [TAPS*BITS-1:0] taps,
  output logic [SUM_W-1:0]     sum
);

  logic [TAPS-1:0][SUM_W-1:0] ext;
  logic [TAPS-1:0][SUM_W-1:0] acc;

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic [BITS-1:0] word;
    logic            fill;
    assign word   = BITS'(tap(TAP_BUS_MAX_W'(taps), BITS, k));
    assign fill   = (SIGNED != 0) ? word[BITS-1] : 1'b0;
    assign ext[k] = {{(SUM_W-BITS){fill}}, word};
    if (k == 0) begin : g_first
      assign acc[k] = ext[k];
    end else begin : g_next
      assign acc[k] = acc[k-1] + ext[k];
    end
  end

  assign sum = acc[TAPS-1];

endmodule

// File: rtl/tap_averager.sv
// Two-stage moving-average over the delay-line tap bus: window sum, rounded
// mean, and a valid flag qualified by a saturating warm-up counter.
module tap_averager
  import tap_averager_pkg::*;
#(
  parameter int TAPS   = 4,
  parameter int BITS   = 8,
  parameter int SIGNED = 0,
  parameter int ROUND  = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [TAPS*BITS-1:0]             i_taps,
  input  logic                             i_clear,
  output logic [sum_width(BITS, TAPS)-1:0] o_sum,
  output logic [BITS-1:0]                  o_avg,
  output logic                             o_valid
);

  localparam int S     = clog2(TAPS);
  localparam int SUM_W = sum_width(BITS, TAPS);
  localparam int CNT_W = clog2(TAPS + 1);
  localparam logic [SUM_W-1:0] HALF = SUM_W'(1) << (S - 1);

  // Headroom of SUM_W guarantees the rounding add cannot overflow.
  function automatic logic [BITS-1:0] rnd(input logic [SUM_W-1:0] x);
    logic [SUM_W-1:0] y;
    logic [SUM_W-1:0] sh;
    y = (ROUND != 0) ? (x + HALF) : x;
    if (SIGNED != 0) sh = $signed(y) >>> S;
    else             sh = y >> S;
    return BITS'(sh);
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             window_full;
  logic [SUM_W-1:0] sum_p0;
  logic [SUM_W-1:0] sum_p1;
  logic             vld_p1;

  assign window_full = (cnt == CNT_W'(TAPS));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) cnt <= '0;
    else if (!window_full) cnt <= cnt + CNT_W'(1);
  end

  // Stage 0 -> 1: combinational window sum captured
  tap_adder #(
    .TAPS  (TAPS),
    .BITS  (BITS),
    .SIGNED(SIGNED),
    .SUM_W (SUM_W)
  ) u_adder (
    .taps(i_taps),
    .sum (sum_p0)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      sum_p1 <= sum_p0;
      vld_p1 <= window_full && !i_clear;
    end
  end

  // Stage 1 -> 2: output registers with divide
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sum   <= '0;
      o_avg   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_sum   <= sum_p1;
      o_avg   <= rnd(sum_p1);
      o_valid <= vld_p1 && !i_clear;
    end
  end

endmodule

// File: tb/tb_tap_averager.sv
// Randomized bench for tap_averager: three configurations share one stimulus
// and are compared each cycle against an arithmetic window model.
module tb_tap_averager;

  localparam int TAPS = 4;
  localparam int BITS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] taps = '0;

  logic [9:0] sum_r, sum_t, sum_s;
  logic [7:0] avg_r, avg_t, avg_s;
  logic       val_r, val_t, val_s;

  int checks   = 0;
  int failures = 0;

  // Model state
  int run     = 0;
  int usum1   = 0;
  int ssum1   = 0;
  int exp_u   = 0;
  int exp_s   = 0;
  bit exp_val = 1'b0;

  always #5 clk = ~clk;

  tap_averager #(.TAPS(TAPS), .BITS(BITS), .SIGNED(0), .ROUND(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_taps(taps), .i_clear(clr),
    .o_sum(sum_r), .o_avg(avg_r), .o_valid(val_r));

  tap_averager #(.TAPS(TAPS), .BITS(BITS), .SIGNED(0), .ROUND(0)) u_trunc (
    .i_clk(clk), .i_rst(rst), .i_taps(taps), .i_clear(clr),
    .o_sum(sum_t), .o_avg(avg_t), .o_valid(val_t));

  tap_averager #(.TAPS(TAPS), .BITS(BITS), .SIGNED(1), .ROUND(1)) u_sgn (
    .i_clk(clk), .i_rst(rst), .i_taps(taps), .i_clear(clr),
    .o_sum(sum_s), .o_avg(avg_s), .o_valid(val_s));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fdiv(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  // Drive one cycle, advance the model across the edge, then compare all outputs.
  task automatic step(input bit r, input bit c, input logic [31:0] t);
    int us, ss;
    rst  = r;
    clr  = c;
    taps = t;
    us = 0;
    ss = 0;
    for (int k = 0; k < TAPS; k++) begin
      logic [7:0] w;
      w  = t[k*8 +: 8];
      us += int'(w);
      ss += int'($signed(w));
    end
    @(posedge clk);
    if (r) begin
      run   = 0;
      exp_u = 0;
      exp_s = 0;
      usum1 = 0;
      ssum1 = 0;
    end else begin
      exp_u = usum1;
      exp_s = ssum1;
      usum1 = us;
      ssum1 = ss;
      run   = c ? 0 : run + 1;
    end
    exp_val = !r && (run >= TAPS + 2);
    @(negedge clk);
    check("rnd_sum",   32'(sum_r), 32'(exp_u & 'h3FF));
    check("rnd_avg",   32'(avg_r), 32'(fdiv(exp_u + 2, TAPS) & 'hFF));
    check("rnd_valid", 32'(val_r), 32'(exp_val));
    check("trn_sum",   32'(sum_t), 32'(exp_u & 'h3FF));
    check("trn_avg",   32'(avg_t), 32'(fdiv(exp_u, TAPS) & 'hFF));
    check("trn_valid", 32'(val_t), 32'(exp_val));
    check("sgn_sum",   32'(sum_s), 32'(exp_s & 'h3FF));
    check("sgn_avg",   32'(avg_s), 32'(fdiv(exp_s + 2, TAPS) & 'hFF));
    check("sgn_valid", 32'(val_s), 32'(exp_val));
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom);
    step(1'b1, 1'b1, $urandom);

    // Directed windows from the plan
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0A0A0A0A);
    check("d_sum40", 32'(sum_r), 32'd40);
    check("d_avg10", 32'(avg_r), 32'd10);
    check("d_val",   32'(val_r), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h04030201);
    check("d_sum10",  32'(sum_r), 32'd10);
    check("d_avg3",   32'(avg_r), 32'd3);
    check("d_trunc2", 32'(avg_t), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'hFFFFFFFF);
    check("d_sum1020", 32'(sum_r), 32'd1020);
    check("d_avg255",  32'(avg_r), 32'd255);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'hFCFDFEFF);
    check("d_ssum", 32'(sum_s), 32'h3F6);
    check("d_savg", 32'(avg_s), 32'hFE);

    // Warm-up, clear at edge 20, reset at edge 30, counted from reset release
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, $urandom);
    for (int e = 1; e <= 40; e++) begin
      step(e == 30, e == 20, $urandom);
      if (e == 5 || e == 20 || e == 25 || e == 30 || e == 35)
        check("t_low", 32'(val_r), 32'd0);
      if (e == 6 || e == 26 || e == 36)
        check("t_high", 32'(val_r), 32'd1);
    end

    // Random traffic with sporadic clears and resets
    for (int i = 0; i < 400; i++) begin
      bit r, c;
      r = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 24) == 0);
      step(r, c, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tap_averager.md
Name: tap_averager

Overview:
- Moving-average stage directly downstream of the parameterised D-FF delay line.
- Consumes the delay line's flattened tap bus, which carries one BITS-wide word per delay stage and is updated every clock.
- Produces the registered window sum, the rounded window mean and a valid flag that stays low until the window holds TAPS real samples.
- Serves as the smoothing/decimation-prep stage in the unit1 datapath.

Parameters:
- TAPS, 4, number of taps on the input bus; power of two, at least 2; must equal the upstream DELAY.
- BITS, 8, width of each tap word and of o_avg.
- SIGNED, 0, 0 = taps are unsigned; 1 = taps are two's-complement.
- ROUND, 1, 1 = round half up before the divide; 0 = truncate (floor).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_taps  in  TAPS*BITS  flattened tap bus; tap k occupies [(k+1)*BITS-1 : k*BITS]; tap 0 is the newest sample.
- i_clear  in  1  synchronous window restart; clears the warm-up count and valid pipeline only.
- o_sum  out  BITS+log2(TAPS)  registered window sum; sign-extended when SIGNED=1.
- o_avg  out  BITS  registered window mean.
- o_valid  out  1  high when o_sum and o_avg reflect a full window.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- While i_rst=1:
  - o_sum, o_avg, o_valid are all 0.
  - Internal stage-1 sum, stage-1 valid and fill counter are all 0.
- Let S = log2(TAPS) and SUM_W = BITS+S. All sums are computed at SUM_W bits, so no overflow is possible.
- Fill counter:
  - Width is ceil(log2(TAPS+1)).
  - Increments on every edge with i_rst=0 and i_clear=0.
  - Saturates at TAPS.
  - window_full = (cnt == TAPS).
- Pipeline, fixed 2-cycle latency from i_taps to outputs:
  - Edge e: sum1 <= sum over k of ext(tap k); v1 <= window_full. ext is zero- or sign-extension to SUM_W, per SIGNED.
  - Edge e+1: o_sum <= sum1; o_avg <= rnd(sum1); o_valid <= v1.
- Divide:
  - ROUND=1: rnd(x) = (x + 2^(S-1)) >> S.
  - ROUND=0: rnd(x) = x >> S.
  - The shift is arithmetic when SIGNED=1 and logical when SIGNED=0.
  - The result always fits BITS; the low BITS of the shifted value are taken.
- Data registers (sum1, o_sum, o_avg) update every cycle regardless of o_valid. Consumers qualify with o_valid.
- Warm-up timing after reset release (edge 1 = first edge with i_rst=0):
  - The upstream delay line has all TAPS taps filled after edge TAPS, and cnt == TAPS at that edge.
  - v1 rises at edge TAPS+1.
  - o_valid rises at edge TAPS+2 and stays high until reset or clear.
- i_clear=1 at edge c:
  - cnt, v1 and o_valid go to 0 at edge c.
  - Counting resumes from edge c+1.
  - o_valid returns at edge c+TAPS+2 if i_clear is not reasserted.
  - Data path is not cleared.
- i_rst and i_clear asserted together: reset takes priority; the result is identical to reset alone.
- Reset mid-operation: all state is zeroed at that edge and full warm-up is repeated.

Decomposition:
- Shared package holds:
  - clog2 constant function.
  - SUM_W derivation.
  - Tap-slice helper function, tap(bus, k), reused by other tap-bus consumers.
- One sub-module: tap_adder. It is the combinational generate-based reduction of TAPS extended words to SUM_W and is instantiated once for stage 1.
- The counter, valid pipeline and rounding stay in the top level.

Test Plan:
- Defaults (TAPS=4, BITS=8, SIGNED=0, ROUND=1), taps all 10 held -> after warm-up o_sum=40, o_avg=10, o_valid=1.
- Taps {1,2,3,4} -> o_sum=10, o_avg=3. Same stimulus with ROUND=0 -> o_avg=2.
- Taps all 255 -> o_sum=1020, o_avg=255; no wrap.
- SIGNED=1, taps {-1,-2,-3,-4} -> o_sum=-10 (10-bit 0x3F6), o_avg=-2 (0xFE).
- Release reset, then drive 1 sample per cycle -> o_valid low through edge 5 and high from edge 6. Assert i_clear for 1 cycle at edge 20 -> o_valid low at edge 20 and high again at edge 26.
- i_rst pulsed at edge 30 during steady operation -> all outputs 0 at edge 30. o_valid returns at edge 36 with the sum matching the new window.
